// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the toy memory responder slice.
package toy_mem_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 30;
  localparam int DEPTH_DEFAULT = 1024;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Word address is in range when every bit above the index field is zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/toy_mem_responder_if.sv
// Core-facing bus bundle of the toy memory responder: fetch, data, preload, status.
interface toy_mem_responder_if;
  import toy_mem_pkg::*;

  logic              READY;
  logic              IREQ;
  logic [ADDR_W-1:0] IADDR;
  logic [DATA_W-1:0] INSTR;
  logic              DREQ;
  logic              DRW;
  logic [ADDR_W-1:0] DADDR;
  logic [DATA_W-1:0] DWDATA;
  logic [DATA_W-1:0] DRDATA;
  logic              LEN;
  logic [ADDR_W-1:0] LADDR;
  logic [DATA_W-1:0] LDATA;
  logic              ERR;
  logic [31:0]       IRD_CNT;
  logic [31:0]       DRD_CNT;
  logic [31:0]       DWR_CNT;

  modport master (
    input  READY, INSTR, DRDATA, ERR, IRD_CNT, DRD_CNT, DWR_CNT,
    output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, LEN, LADDR, LDATA
  );

  modport slave (
    output READY, INSTR, DRDATA, ERR, IRD_CNT, DRD_CNT, DWR_CNT,
    input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, LEN, LADDR, LDATA
  );

endinterface

// File: rtl/toy_mem_array.sv
// Word array with two enabled synchronous read ports (read-old) and one write port; no reset.
module toy_mem_array
  import toy_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re0,
  input  logic [AW-1:0]     i_raddr0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_re1,
  input  logic [AW-1:0]     i_raddr1,
  output logic [DATA_W-1:0] o_rdata1
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re0) r_rdata0 <= r_mem[i_raddr0];
    if (i_re1) r_rdata1 <= r_mem[i_raddr1];
  end

  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/toy_mem_responder.sv
// Memory-side responder for RISC_TOY: clear-after-reset, fetch/load/store/preload on one array.
// Define TOY_MEM_STATS_EN to build the access counters; otherwise they read 0.
module toy_mem_responder
  import toy_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  toy_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t            r_state;
  logic [AW-1:0]     r_clr_addr;
  logic              r_ready;
  logic              r_err;
  logic              r_i_valid;
  logic              r_d_valid;

  logic              w_i_inr, w_d_inr, w_l_inr;
  logic              w_run, w_fetch, w_load, w_pre, w_store, w_oor;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata_i, w_rdata_d;

  assign w_i_inr = in_range(bus.IADDR, AW);
  assign w_d_inr = in_range(bus.DADDR, AW);
  assign w_l_inr = in_range(bus.LADDR, AW);

  assign w_run   = (r_state == ST_RUN) && !RST;
  assign w_fetch = w_run && bus.IREQ && w_i_inr;
  assign w_load  = w_run && bus.DREQ && !bus.DRW && w_d_inr;
  assign w_pre   = w_run && bus.LEN && w_l_inr;
  // Any preload request claims the write port, so a simultaneous core store is dropped.
  assign w_store = w_run && bus.DREQ && bus.DRW && w_d_inr && !bus.LEN;
  assign w_oor   = w_run && ((bus.IREQ && !w_i_inr) || (bus.DREQ && !w_d_inr) ||
                             (bus.LEN && !w_l_inr));

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == ST_CLEAR && !RST) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
    end else if (w_pre) begin
      w_we    = 1'b1;
      w_waddr = bus.LADDR[AW-1:0];
      w_wdata = bus.LDATA;
    end else if (w_store) begin
      w_we    = 1'b1;
      w_waddr = bus.DADDR[AW-1:0];
      w_wdata = bus.DWDATA;
    end
  end

  toy_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk    (CLK),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_re0    (w_fetch),
    .i_raddr0 (bus.IADDR[AW-1:0]),
    .o_rdata0 (w_rdata_i),
    .i_re1    (w_load),
    .i_raddr1 (bus.DADDR[AW-1:0]),
    .o_rdata1 (w_rdata_d)
  );

  // The array has no reset, so the valid flags supply the zero on reset and out-of-range reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_i_valid  <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == AW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.IREQ) r_i_valid <= w_i_inr;
          if (bus.DREQ && !bus.DRW) r_d_valid <= w_d_inr;
          if (w_oor) r_err <= 1'b1;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.READY  = r_ready;
  assign bus.ERR    = r_err;
  assign bus.INSTR  = r_i_valid ? w_rdata_i : '0;
  assign bus.DRDATA = r_d_valid ? w_rdata_d : '0;

`ifdef TOY_MEM_STATS_EN
  logic [31:0] r_ird_cnt, r_drd_cnt, r_dwr_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ird_cnt <= '0;
      r_drd_cnt <= '0;
      r_dwr_cnt <= '0;
    end else begin
      if (w_fetch) r_ird_cnt <= r_ird_cnt + 1'b1;
      if (w_load)  r_drd_cnt <= r_drd_cnt + 1'b1;
      if (w_store) r_dwr_cnt <= r_dwr_cnt + 1'b1;
    end
  end

  assign bus.IRD_CNT = r_ird_cnt;
  assign bus.DRD_CNT = r_drd_cnt;
  assign bus.DWR_CNT = r_dwr_cnt;
`else
  assign bus.IRD_CNT = '0;
  assign bus.DRD_CNT = '0;
  assign bus.DWR_CNT = '0;
`endif

endmodule

// File: tb/tb_toy_mem_responder.sv
// Scoreboard bench for toy_mem_responder: directed scenarios followed by random traffic.
module tb_toy_mem_responder;

  localparam int TB_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_mem_responder_if bus ();

  toy_mem_responder #(
    .DEPTH (TB_DEPTH)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] drdata;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [31:0] dwr;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Stimulus for the next cycle
  logic        s_rst, s_ireq, s_dreq, s_drw, s_len;
  logic [29:0] s_iaddr, s_daddr, s_laddr;
  logic [31:0] s_dwdata, s_ldata;

  // Reference model state
  logic [31:0] m_mem [TB_DEPTH];
  int          m_clear_left = TB_DEPTH;
  logic [31:0] m_instr = '0, m_drdata = '0;
  logic [31:0] m_ird = '0, m_drd = '0, m_dwr = '0;
  logic        m_ready = 1'b0, m_err = 1'b0;

  task automatic idle();
    s_rst = 1'b0; s_ireq = 1'b0; s_dreq = 1'b0; s_drw = 1'b0; s_len = 1'b0;
    s_iaddr = '0; s_daddr = '0; s_laddr = '0; s_dwdata = '0; s_ldata = '0;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    rst        = s_rst;
    bus.IREQ   = s_ireq;   bus.IADDR  = s_iaddr;
    bus.DREQ   = s_dreq;   bus.DRW    = s_drw;
    bus.DADDR  = s_daddr;  bus.DWDATA = s_dwdata;
    bus.LEN    = s_len;    bus.LADDR  = s_laddr;  bus.LDATA = s_ldata;

    if (s_rst) begin
      for (int i = 0; i < TB_DEPTH; i++) m_mem[i] = '0;
      m_clear_left = TB_DEPTH;
      m_ready = 1'b0; m_err = 1'b0;
      m_instr = '0; m_drdata = '0;
      m_ird = '0; m_drd = '0; m_dwr = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) m_ready = 1'b1;
    end else begin
      // reads see the array before this cycle's writes
      if (s_ireq) begin
        if (s_iaddr < TB_DEPTH) begin m_instr = m_mem[int'(s_iaddr)]; m_ird++; end
        else begin m_instr = '0; m_err = 1'b1; end
      end
      if (s_dreq && !s_drw) begin
        if (s_daddr < TB_DEPTH) begin m_drdata = m_mem[int'(s_daddr)]; m_drd++; end
        else begin m_drdata = '0; m_err = 1'b1; end
      end
      if (s_dreq && s_drw) begin
        if (s_daddr >= TB_DEPTH) m_err = 1'b1;
        else if (!s_len) begin m_mem[int'(s_daddr)] = s_dwdata; m_dwr++; end
      end
      if (s_len) begin
        if (s_laddr < TB_DEPTH) m_mem[int'(s_laddr)] = s_ldata;
        else m_err = 1'b1;
      end
    end

    e.instr = m_instr; e.drdata = m_drdata;
    e.ready = m_ready; e.err = m_err;
`ifdef TOY_MEM_STATS_EN
    e.ird = m_ird; e.drd = m_drd; e.dwr = m_dwr;
`else
    e.ird = '0; e.drd = '0; e.dwr = '0;
`endif
    q.push_back(e);
    idle();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("READY",   {31'b0, bus.READY}, {31'b0, e.ready});
        chk("ERR",     {31'b0, bus.ERR},   {31'b0, e.err});
        chk("INSTR",   bus.INSTR,   e.instr);
        chk("DRDATA",  bus.DRDATA,  e.drdata);
        chk("IRD_CNT", bus.IRD_CNT, e.ird);
        chk("DRD_CNT", bus.DRD_CNT, e.drd);
        chk("DWR_CNT", bus.DWR_CNT, e.dwr);
      end
    end
  end

  initial begin : stimulus
    idle();
    rst = 1'b1;
    bus.IREQ = 1'b0; bus.IADDR = '0; bus.DREQ = 1'b0; bus.DRW = 1'b0;
    bus.DADDR = '0; bus.DWDATA = '0; bus.LEN = 1'b0; bus.LADDR = '0; bus.LDATA = '0;

    // reset release and clear
    s_rst = 1'b1; step();
    s_rst = 1'b1; step();
    repeat (TB_DEPTH) step();
    s_ireq = 1'b1; s_iaddr = 30'd5; step();
    step();

    // preload then fetch, then hold
    s_len = 1'b1; s_laddr = 30'd3; s_ldata = 32'h0123_4567; step();
    s_ireq = 1'b1; s_iaddr = 30'd3; step();
    step(); step();

    // store with same-cycle fetch, then load
    s_dreq = 1'b1; s_drw = 1'b1; s_daddr = 30'd7; s_dwdata = 32'hDEAD_BEEF;
    s_ireq = 1'b1; s_iaddr = 30'd7; step();
    s_dreq = 1'b1; s_daddr = 30'd7; step();
    step();

    // preload / store collision
    s_len = 1'b1; s_laddr = 30'd2; s_ldata = 32'hAAAA_AAAA;
    s_dreq = 1'b1; s_drw = 1'b1; s_daddr = 30'd2; s_dwdata = 32'h5555_5555; step();
    s_dreq = 1'b1; s_daddr = 30'd2; step();
    step();

    // out of range
    s_dreq = 1'b1; s_daddr = 30'h10; step();
    s_dreq = 1'b1; s_daddr = 30'd0; step();
    s_dreq = 1'b1; s_drw = 1'b1; s_daddr = 30'h10; s_dwdata = 32'hFFFF_FFFF; step();
    s_dreq = 1'b1; s_daddr = 30'd0; step();
    repeat (3) step();

    // mid-run reset
    s_len = 1'b1; s_laddr = 30'd9; s_ldata = 32'h1; step();
    s_ireq = 1'b1; s_iaddr = 30'd9; step();
    repeat (4) step();
    s_rst = 1'b1; step();
    repeat (TB_DEPTH) step();
    s_ireq = 1'b1; s_iaddr = 30'd9; step();
    s_dreq = 1'b1; s_daddr = 30'd9; step();
    step();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      s_rst    = ($urandom_range(0, 199) == 0);
      s_ireq   = $urandom_range(0, 1);
      s_iaddr  = 30'($urandom_range(0, 19));
      s_dreq   = $urandom_range(0, 1);
      s_drw    = $urandom_range(0, 1);
      s_daddr  = 30'($urandom_range(0, 19));
      s_dwdata = $urandom;
      s_len    = ($urandom_range(0, 3) == 0);
      s_laddr  = 30'($urandom_range(0, 19));
      s_ldata  = $urandom;
      step();
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
